// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM encoding, default geometry/pattern and width helper for seq_det_prog
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;
  localparam int PAT_W_MAX = 32;
  localparam int DEF_PAT_W = 8;
  localparam logic [PAT_W_MAX-1:0] DEF_RST_PAT = 32'h5A;
  localparam int DEF_RST_LEN = 7;
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating counter, clear takes effect before a same-cycle increment
module seq_det_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= W'(inc);
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial pattern detector with registered match pulse and hit counter
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
  parameter int               RST_LEN = DEF_RST_LEN,
  parameter logic             RST_OVL = 1'b1,
  localparam int              LEN_W   = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_vld,
  input  logic             in_bit,
  input  logic             cfg_wr,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);
  logic [PAT_W-1:0] pat, hist, hist_n, mask;
  logic [LEN_W-1:0] len, fill, fill_n;
  logic ovl, acc, legal, load, hit;
  state_t state, state_n;
  always_comb begin
    acc = en & in_vld & ~cfg_wr;
    legal = cfg_len != '0 && cfg_len <= LEN_W'(PAT_W);
    load = cfg_wr & legal;
    hist_n = {hist[PAT_W-2:0], in_bit};
    for (int i = 0; i < PAT_W; i++) mask[i] = i < int'(len);
    hit = acc && fill >= len - LEN_W'(1) && ((hist_n ^ pat) & mask) == '0;
    fill_n = (hit && !ovl) ? '0 : (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
    state_n = !en ? IDLE
            : (load || state == IDLE || (hit && !ovl)) ? FILL
            : (acc && fill >= len - LEN_W'(1)) ? HUNT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= RST_PAT;
      len <= LEN_W'(RST_LEN);
      ovl <= RST_OVL;
      hist <= '0;
      fill <= '0;
      state <= IDLE;
      match <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_n;
      match <= hit;
      cfg_err <= cfg_wr & ~legal;
      if (load) begin
        pat <= cfg_pat;
        len <= cfg_len;
        ovl <= cfg_ovl;
      end
      if (!en || load) begin
        hist <= '0;
        fill <= '0;
      end else if (acc) begin
        hist <= hist_n;
        fill <= fill_n;
      end
    end
  end
  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(hit),
    .cnt(match_cnt)
  );
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: scenario tasks with a match/count scoreboard against two detector instances
module tb_seq_det_prog;
  logic clk = 1'b0;
  logic rst, en, in_vld, in_bit, cfg_wr, cfg_ovl, cnt_clr;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic match, cfg_err, match2, cfg_err2;
  logic [15:0] match_cnt;
  logic [1:0] match_cnt2;
  int n_cmp = 0, n_bad = 0;
  logic exp_m[$];
  int exp_c[$];
  logic e;
  int ec;

  seq_det_prog dut (
    .clk(clk), .rst(rst), .en(en), .in_vld(in_vld), .in_bit(in_bit),
    .cfg_wr(cfg_wr), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );
  seq_det_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_vld(in_vld), .in_bit(in_bit),
    .cfg_wr(cfg_wr), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .cnt_clr(cnt_clr), .match(match2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_wr = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o;
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic flush;
    en = 1'b0; in_vld = 1'b0; cnt_clr = 1'b1;
    cyc();
    en = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; in_vld = 1'b0; in_bit = 1'b0; cfg_wr = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0; cnt_clr = 1'b0;
    cyc(); cyc();
    n_cmp++;
    if (match !== 1'b0 || match_cnt !== 16'd0 || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: match=%b cnt=%0d cfg_err=%b, required 0/0/0", match, match_cnt, cfg_err);
    end
    rst = 1'b0; en = 1'b1;
  endtask

  task automatic test_overlap;
    logic [11:0] s = 12'b101101011010;
    for (int i = 11; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = s[i];
      exp_m.push_back(i == 5 || i == 0);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL overlap bit%0d: match=%b required %b", 12 - i, match, e); end
    end
    in_vld = 1'b0;
    n_cmp++;
    if (match_cnt !== 16'd2) begin n_bad++; $display("FAIL overlap cnt: got %0d required 2", match_cnt); end
  endtask

  task automatic test_nonoverlap;
    logic [11:0] s = 12'b101101011010;
    flush();
    cfg(8'h5A, 4'd7, 1'b0);
    for (int i = 11; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = s[i];
      exp_m.push_back(i == 5);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL nonoverlap bit%0d: match=%b required %b", 12 - i, match, e); end
    end
    in_vld = 1'b0;
    n_cmp++;
    if (match_cnt !== 16'd1) begin n_bad++; $display("FAIL nonoverlap cnt: got %0d required 1", match_cnt); end
  endtask

  task automatic test_cfg_err;
    logic [6:0] s = 7'b1011010;
    logic [3:0] bad [2] = '{4'd0, 4'd9};
    flush();
    for (int k = 0; k < 2; k++) begin
      cfg(8'hFF, bad[k], 1'b1);
      n_cmp++;
      if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err len=%0d: cfg_err=%b required 1", bad[k], cfg_err); end
      cyc();
      n_cmp++;
      if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_err pulse len=%0d: cfg_err=%b required 0", bad[k], cfg_err); end
    end
    for (int i = 6; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = s[i];
      exp_m.push_back(i == 0);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL cfg_err keep bit%0d: match=%b required %b", 7 - i, match, e); end
    end
    in_vld = 1'b0;
  endtask

  task automatic test_len3_gaps;
    logic [8:0] v = 9'b101011010;
    logic [8:0] b = 9'b111011111;
    logic [8:0] h = 9'b000011010;
    flush();
    cfg(8'h07, 4'd3, 1'b1);
    for (int i = 8; i >= 0; i--) begin
      in_vld = v[i]; in_bit = b[i];
      exp_m.push_back(h[i]);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL len3 step%0d: match=%b required %b", 9 - i, match, e); end
    end
    in_vld = 1'b0;
    n_cmp++;
    if (match_cnt !== 16'd3) begin n_bad++; $display("FAIL len3 cnt: got %0d required 3", match_cnt); end
  endtask

  task automatic test_cfg_collide;
    logic [3:0] pre = 4'b1011;
    logic [9:0] s = 10'b0101011010;
    flush();
    cfg(8'h5A, 4'd7, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = pre[i];
      exp_m.push_back(1'b0);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL collide pre%0d: match=%b required %b", 4 - i, match, e); end
    end
    cfg_wr = 1'b1; in_vld = 1'b1; in_bit = 1'b0;
    exp_m.push_back(1'b0);
    cyc();
    cfg_wr = 1'b0;
    e = exp_m.pop_front();
    n_cmp++;
    if (match !== e) begin n_bad++; $display("FAIL collide cfg cycle: match=%b required %b", match, e); end
    for (int i = 9; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = s[i];
      exp_m.push_back(i == 0);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL collide bit%0d: match=%b required %b", 10 - i, match, e); end
    end
    in_vld = 1'b0;
  endtask

  task automatic test_en_low;
    logic [3:0] pre = 4'b1011;
    logic [9:0] s = 10'b0101011010;
    flush();
    cfg(8'h5A, 4'd7, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = pre[i];
      exp_m.push_back(1'b0);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL en_low pre%0d: match=%b required %b", 4 - i, match, e); end
    end
    en = 1'b0; in_vld = 1'b1; in_bit = 1'b0;
    exp_m.push_back(1'b0);
    cyc();
    en = 1'b1;
    e = exp_m.pop_front();
    n_cmp++;
    if (match !== e) begin n_bad++; $display("FAIL en_low idle cycle: match=%b required %b", match, e); end
    for (int i = 9; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = s[i];
      exp_m.push_back(i == 0);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL en_low bit%0d: match=%b required %b", 10 - i, match, e); end
    end
    in_vld = 1'b0;
  endtask

  task automatic test_cnt_sat;
    logic [8:0] v = 9'b111111110;
    logic [8:0] b = 9'b111111100;
    logic [8:0] c = 9'b000100001;
    logic [8:0] h = 9'b111111100;
    int cv [9] = '{1, 2, 3, 1, 2, 3, 3, 3, 0};
    flush();
    cfg(8'h01, 4'd1, 1'b1);
    for (int i = 8; i >= 0; i--) begin
      in_vld = v[i]; in_bit = b[i]; cnt_clr = c[i];
      exp_m.push_back(h[i]);
      exp_c.push_back(cv[8 - i]);
      cyc();
      e = exp_m.pop_front();
      ec = exp_c.pop_front();
      n_cmp++;
      if (match2 !== e || int'(match_cnt2) != ec) begin
        n_bad++;
        $display("FAIL cnt_sat step%0d: match=%b cnt=%0d required %b/%0d", 9 - i, match2, match_cnt2, e, ec);
      end
    end
    in_vld = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_rst_mid;
    logic [5:0] pre = 6'b101101;
    logic [6:0] s = 7'b1011010;
    flush();
    cfg(8'hFF, 4'd8, 1'b0);
    for (int i = 5; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = pre[i];
      cyc();
    end
    rst = 1'b1; in_bit = 1'b0;
    exp_m.push_back(1'b0);
    cyc();
    rst = 1'b0;
    e = exp_m.pop_front();
    n_cmp++;
    if (match !== e || match_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mid: match=%b cnt=%0d required %b/0", match, match_cnt, e);
    end
    for (int i = 6; i >= 0; i--) begin
      in_vld = 1'b1; in_bit = s[i];
      exp_m.push_back(i == 0);
      cyc();
      e = exp_m.pop_front();
      n_cmp++;
      if (match !== e) begin n_bad++; $display("FAIL rst_mid bit%0d: match=%b required %b", 7 - i, match, e); end
    end
    in_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_cfg_err();
    test_len3_gaps();
    test_cfg_collide();
    test_en_low();
    test_cnt_sat();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
